// File: rtl/arm_control_sequencer.sv
// arm_control_sequencer: fetch/decode/execute state sequencer for the ARM datapath
// Ports: clk, reset (sync, active-high); enc_in/cond_ok sampled in DECODE; moc memory complete;
// state current code; mem_req/mem_rw memory request and direction; ld_ir/abort/illegal pulses.
module arm_control_sequencer #(
    parameter int MOC_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] enc_in,
    input  logic       cond_ok,
    input  logic       moc,
    output logic [5:0] state,
    output logic       mem_req,
    output logic       mem_rw,
    output logic       ld_ir,
    output logic       abort,
    output logic       illegal
);
    typedef enum logic [5:0] {
        S_RESET       = 6'd0,
        S_FETCH_ADDR  = 6'd1,
        S_FETCH_READ  = 6'd2,
        S_PC_INC      = 6'd3,
        S_DECODE      = 6'd4,
        S_BRANCH_LINK = 6'd44,
        S_LINK_WR     = 6'd45,
        S_MEM_WAIT    = 6'd48,
        S_LOAD_WR     = 6'd49,
        S_BASE_WB     = 6'd50,
        S_ABORT       = 6'd63
    } state_t;
    localparam logic [7:0] TO_LAST = 8'(MOC_TIMEOUT - 1);
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       l_q, l_d, w_q, w_d;
    logic       sup, is_ls, timeout;
    assign sup     = enc_in inside {[5:7], [12:16], 18, [20:24], 26, [35:41], 43, 44};
    assign is_ls   = state_q inside {[12:16], 18, [20:24], 26, [35:41]};
    // counter holds cycles already spent waiting; this cycle would be the last allowed one
    assign timeout = cnt_q >= TO_LAST;
    always_comb begin
        state_d = S_FETCH_ADDR;
        l_d     = l_q;
        w_d     = w_q;
        case (state_q)
            S_FETCH_ADDR:  state_d = S_FETCH_READ;
            S_FETCH_READ:  state_d = moc ? S_PC_INC : (timeout ? S_ABORT : S_FETCH_READ);
            S_PC_INC:      state_d = S_DECODE;
            S_DECODE: begin
                if (cond_ok && sup) begin
                    state_d = state_t'(enc_in);
                    l_d     = enc_in inside {[20:24], 26, [39:41]};
                    w_d     = enc_in inside {[14:16], 18, [22:24], 26, 36, 37, 40, 41};
                end
            end
            S_BRANCH_LINK: state_d = S_LINK_WR;
            S_MEM_WAIT:    state_d = moc ? (l_q ? S_LOAD_WR : (w_q ? S_BASE_WB : S_FETCH_ADDR))
                                         : (timeout ? S_ABORT : S_MEM_WAIT);
            S_LOAD_WR:     state_d = w_q ? S_BASE_WB : S_FETCH_ADDR;
            S_ABORT: begin
                l_d = 1'b0;
                w_d = 1'b0;
            end
            default:       state_d = is_ls ? S_MEM_WAIT : S_FETCH_ADDR;
        endcase
        cnt_d = (state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            l_q     <= 1'b0;
            w_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            w_q     <= w_d;
        end
    end
    assign state   = state_q;
    assign mem_req = (state_q == S_FETCH_READ) || (state_q == S_MEM_WAIT);
    assign mem_rw  = (state_q == S_FETCH_READ) ? 1'b1 : (state_q == S_MEM_WAIT) ? l_q : 1'b0;
    assign ld_ir   = (state_q == S_FETCH_READ) && moc;
    assign abort   = state_q == S_ABORT;
    assign illegal = (state_q == S_DECODE) && cond_ok && (enc_in != 6'd0) && !sup;
endmodule

// File: tb/tb_arm_control_sequencer.sv
// tb_arm_control_sequencer: directed vector bench for arm_control_sequencer
module tb_arm_control_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] enc_in = '0;
    logic       cond_ok = 1'b0;
    logic       moc = 1'b0;
    logic [5:0] state;
    logic       mem_req, mem_rw, ld_ir, abort, illegal;
    int checks = 0;
    int errors = 0;

    arm_control_sequencer #(.MOC_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .enc_in(enc_in), .cond_ok(cond_ok), .moc(moc),
        .state(state), .mem_req(mem_req), .mem_rw(mem_rw), .ld_ir(ld_ir),
        .abort(abort), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [5:0] enc;
        logic       cond;
        logic       moc;
        logic [5:0] st;
        logic       req, rw, ld, ab, il;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rst, logic [5:0] enc, logic cond, logic m,
                                logic [5:0] st, logic req, logic rw, logic ld, logic ab, logic il);
        vec_t v;
        v.rst = rst; v.enc = enc; v.cond = cond; v.moc = m;
        v.st = st; v.req = req; v.rw = rw; v.ld = ld; v.ab = ab; v.il = il;
        return v;
    endfunction

    // drive one cycle of inputs, compare outputs mid-cycle, then advance one edge
    task automatic apply(input string name, input vec_t v);
        logic [10:0] act, exp;
        reset = v.rst; enc_in = v.enc; cond_ok = v.cond; moc = v.moc;
        #3;
        act = {state, mem_req, mem_rw, ld_ir, abort, illegal};
        exp = {v.st, v.req, v.rw, v.ld, v.ab, v.il};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got state=%0d req=%b rw=%b ld=%b ab=%b il=%b, expected state=%0d req=%b rw=%b ld=%b ab=%b il=%b",
                     name, state, mem_req, mem_rw, ld_ir, abort, illegal,
                     v.st, v.req, v.rw, v.ld, v.ab, v.il);
        end
        @(posedge clk);
        #1;
    endtask

    // plain non-memory state, no pulses
    function automatic vec_t ps(logic [5:0] st);
        return mk(0, 0, 0, 0, st, 0, 0, 0, 0, 0);
    endfunction

    initial begin
        @(posedge clk);
        #1;
        vq.push_back(ps(0));
        // data processing
        vq.push_back(ps(1));
        vq.push_back(mk(0, 0, 0, 1, 2, 1, 1, 1, 0, 0));
        vq.push_back(ps(3));
        vq.push_back(mk(0, 5, 1, 0, 4, 0, 0, 0, 0, 0));
        vq.push_back(ps(5));
        // load pre-indexed with writeback, three wait cycles
        vq.push_back(ps(1));
        vq.push_back(mk(0, 0, 0, 1, 2, 1, 1, 1, 0, 0));
        vq.push_back(ps(3));
        vq.push_back(mk(0, 22, 1, 0, 4, 0, 0, 0, 0, 0));
        vq.push_back(ps(22));
        for (int i = 0; i < 3; i++) vq.push_back(mk(0, 0, 0, 0, 48, 1, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 48, 1, 1, 0, 0, 0));
        vq.push_back(ps(49));
        vq.push_back(ps(50));
        // store offset, immediate moc
        vq.push_back(ps(1));
        vq.push_back(mk(0, 0, 0, 1, 2, 1, 1, 1, 0, 0));
        vq.push_back(ps(3));
        vq.push_back(mk(0, 12, 1, 0, 4, 0, 0, 0, 0, 0));
        vq.push_back(ps(12));
        vq.push_back(mk(0, 0, 0, 1, 48, 1, 0, 0, 0, 0));
        // condition fail
        vq.push_back(ps(1));
        vq.push_back(mk(0, 0, 0, 1, 2, 1, 1, 1, 0, 0));
        vq.push_back(ps(3));
        vq.push_back(mk(0, 43, 0, 0, 4, 0, 0, 0, 0, 0));
        // illegal code
        vq.push_back(ps(1));
        vq.push_back(mk(0, 0, 0, 1, 2, 1, 1, 1, 0, 0));
        vq.push_back(ps(3));
        vq.push_back(mk(0, 9, 1, 0, 4, 0, 0, 0, 0, 1));
        // enc_in = 0 with cond_ok is a no-op, not illegal
        vq.push_back(ps(1));
        vq.push_back(mk(0, 0, 0, 1, 2, 1, 1, 1, 0, 0));
        vq.push_back(ps(3));
        vq.push_back(mk(0, 0, 1, 0, 4, 0, 0, 0, 0, 0));
        // branch with link
        vq.push_back(ps(1));
        vq.push_back(mk(0, 0, 0, 1, 2, 1, 1, 1, 0, 0));
        vq.push_back(ps(3));
        vq.push_back(mk(0, 44, 1, 0, 4, 0, 0, 0, 0, 0));
        vq.push_back(ps(44));
        vq.push_back(ps(45));
        // reset while waiting in MEM_WAIT on a load
        vq.push_back(ps(1));
        vq.push_back(mk(0, 0, 0, 1, 2, 1, 1, 1, 0, 0));
        vq.push_back(ps(3));
        vq.push_back(mk(0, 20, 1, 0, 4, 0, 0, 0, 0, 0));
        vq.push_back(ps(20));
        vq.push_back(mk(0, 0, 0, 0, 48, 1, 1, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 48, 1, 1, 0, 0, 0));
        vq.push_back(ps(0));
        vq.push_back(ps(1));
        vq.push_back(mk(0, 0, 0, 1, 2, 1, 1, 1, 0, 0));
        vq.push_back(ps(3));
        vq.push_back(mk(0, 0, 0, 0, 4, 0, 0, 0, 0, 0));
        foreach (vq[i]) apply($sformatf("vec%0d", i), vq[i]);

        // fetch timeout: 15 cycles in 2 then ABORT
        apply("to_fetch_start", ps(1));
        for (int i = 0; i < 15; i++) apply($sformatf("to_fetch_wait%0d", i), mk(0, 0, 0, 0, 2, 1, 1, 0, 0, 0));
        apply("to_fetch_abort", mk(0, 0, 0, 0, 63, 0, 0, 0, 1, 0));
        apply("to_fetch_ret", ps(1));
        // moc on the last allowed cycle wins over abort
        for (int i = 0; i < 14; i++) apply($sformatf("late_wait%0d", i), mk(0, 0, 0, 0, 2, 1, 1, 0, 0, 0));
        apply("late_moc", mk(0, 0, 0, 1, 2, 1, 1, 1, 0, 0));
        apply("late_pcinc", ps(3));
        // memory-wait timeout on a load
        apply("to_mem_dec", mk(0, 20, 1, 0, 4, 0, 0, 0, 0, 0));
        apply("to_mem_addr", ps(20));
        for (int i = 0; i < 15; i++) apply($sformatf("to_mem_wait%0d", i), mk(0, 0, 0, 0, 48, 1, 1, 0, 0, 0));
        apply("to_mem_abort", mk(0, 0, 0, 0, 63, 0, 0, 0, 1, 0));
        apply("to_mem_ret", ps(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arm_control_sequencer.md
Name: arm_control_sequencer

Overview:
- Control-unit state sequencer for the ARM datapath.
- Consumes the 6-bit instruction state code produced by the instruction encoder and steps the datapath through fetch, decode and per-class execution states.
- Handles the memory-complete handshake, latches load/store attributes and returns to fetch.
- A downstream microcode/control ROM indexes on the current-state output.

Parameters:
- MOC_TIMEOUT, 15: maximum cycles a memory state waits for moc before aborting. Valid range 1..255.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high; one clock; resets all state
- enc_in  input  6  instruction state code from the encoder; sampled only in DECODE
- cond_ok  input  1  instruction condition passed (from condition tester); sampled only in DECODE
- moc  input  1  memory operation complete
- state  output  6  current state code
- mem_req  output  1  memory request active
- mem_rw  output  1  1 = read, 0 = write; valid while mem_req=1
- ld_ir  output  1  one-cycle pulse: load instruction register
- abort  output  1  one-cycle pulse: memory timeout
- illegal  output  1  one-cycle pulse: unsupported code at DECODE

Behaviour:
- Reset (reset=1 at an edge), from any state including mid-wait:
  - state=0, timeout counter=0, latched L/W=0.
  - All pulse outputs=0.
- Next edge after reset deasserts: state 0 -> 1.
- Fetch sequence:
  - 1 FETCH_ADDR -> 2.
  - 2 FETCH_READ: mem_req=1, mem_rw=1. Stays in 2 until moc=1.
    - On the moc=1 edge: ld_ir pulses for the same cycle moc is seen (combinational from state==2 && moc), then -> 3.
  - 3 PC_INC -> 4.
- 4 DECODE:
  - If cond_ok=0 or enc_in=0: -> 1.
  - Else if enc_in is in the supported set: -> enc_in.
  - Else: illegal=1 for this cycle, -> 1.
  - Supported set: 5,6,7,12..16,18,20..24,26,35..41,43,44.
- Data processing (5,6,7): one cycle -> 1.
- Branch:
  - 43 -> 1.
  - 44 -> 45 LINK_WR (link register write) -> 1.
- Load/store entry states (12..16,18,20..24,26,35..41):
  - One address-compute cycle, then -> 48 MEM_WAIT.
  - On entry, latch two attributes:
    - L (load) = 1 for 20,21,22,23,24,26,39,40,41.
    - W (base writeback) = 1 for 14,15,16,18,22,23,24,26,36,37,40,41.
- 48 MEM_WAIT: mem_req=1, mem_rw=L. On the moc=1 edge:
  - L=1: -> 49.
  - L=0 and W=1: -> 50.
  - L=0 and W=0: -> 1.
- 49 LOAD_WR: if W=1 -> 50, else -> 1.
- 50 BASE_WB -> 1.
- Timeout, states 2 and 48:
  - Counter clears on entry to the state and increments each cycle moc=0.
  - If the counter reaches MOC_TIMEOUT with moc still 0: -> 63 ABORT.
  - moc=1 on the same cycle the counter reaches MOC_TIMEOUT counts as success; moc wins over abort.
- 63 ABORT: abort=1 for this cycle, -> 1. L and W clear.
- mem_req=0 and mem_rw=0 in every state except 2 and 48.
- Any unreachable state code (e.g. 8, 60) -> 1 on the next edge, no pulses.
- Latency:
  - Minimum instruction with moc=1 immediately: data processing = 6 cycles from state 1 to a return to 1.
  - Load with writeback = 9 cycles.
- enc_in and cond_ok are ignored outside DECODE.

Test Plan:
- Reset mid-wait: hold in 48 with moc=0, assert reset 1 cycle -> next state=0, mem_req=0; then 1,2.
- Data-processing path: moc=1 in state 2, enc_in=5, cond_ok=1 -> state sequence 1,2,3,4,5,1; ld_ir=1 only in the state-2 cycle.
- Load pre-indexed: enc_in=22, moc low 3 cycles in 48 -> 4,22,48,48,48,48,49,50,1; mem_rw=1 throughout 48.
- Store offset: enc_in=12 -> 4,12,48,1 on immediate moc; mem_rw=0 in 48.
- Condition fail and illegal:
  - cond_ok=0, enc_in=43 -> 4,1, illegal=0.
  - cond_ok=1, enc_in=9 -> 4,1, illegal=1 for one cycle.
- Timeout with MOC_TIMEOUT=15: moc held 0 in state 2 -> 15 cycles in 2, then 63 with abort=1 for one cycle, then 1. Repeat with moc=1 on the 15th cycle -> 3, abort=0.
